seq_detector_param: RTL and testbench

//  Parametrised Moore serial-pattern detector, successor to the fixed-pattern FSM detector.

---
 rtl/seq_det_pkg.sv | 26 ++
 rtl/seq_det_shreg.sv | 44 ++++
 rtl/seq_detector_param.sv | 109 ++++++++++
 tb/tb_seq_detector_param.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/seq_det_pkg.sv
// Shared definitions for the parametrised serial-pattern detector:
// FSM state encoding plus length-clamp and mask helpers.
package seq_det_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HIT  = 2'd2
  } state_e;

  localparam int unsigned DEFAULT_MAX_LEN = 8;

  // A zero length would never complete a match, so it is promoted to 1.
  function automatic int unsigned clamp_len(input int unsigned len,
                                            input int unsigned max_len);
    if (len == 0)       return 1;
    if (len > max_len)  return max_len;
    return len;
  endfunction

  function automatic logic mask_bit(input int unsigned idx,
                                    input int unsigned len);
    return (idx < len);
  endfunction

endpackage

// File: rtl/seq_det_shreg.sv
// History shift register and saturating fill counter for seq_detector_param.
// Exposes the post-shift values so the caller can compare against them in the same cycle.
module seq_det_shreg
  import seq_det_pkg::*;
#(
  parameter int unsigned MAX_LEN = DEFAULT_MAX_LEN,
  parameter int unsigned LEN_W   = $clog2(MAX_LEN + 1)
) (
  input  logic               i_clk,
  input  logic               i_rstn,
  input  logic               i_shift,
  input  logic               i_clear,
  input  logic               i_clear_fill,
  input  logic               i_seq,
  input  logic [LEN_W-1:0]   i_len,
  output logic [MAX_LEN-1:0] o_history_next,
  output logic [LEN_W-1:0]   o_fill_next
);

  logic [MAX_LEN-1:0] r_history;
  logic [LEN_W-1:0]   r_fill;
  logic [MAX_LEN-1:0] w_history_next;
  logic [LEN_W-1:0]   w_fill_next;

  assign w_history_next = {r_history[MAX_LEN-2:0], i_seq};
  assign w_fill_next    = (r_fill >= i_len) ? i_len : r_fill + LEN_W'(1);

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_history <= '0;
      r_fill    <= '0;
    end else if (i_clear) begin
      r_history <= '0;
      r_fill    <= '0;
    end else if (i_shift) begin
      r_history <= w_history_next;
      r_fill    <= i_clear_fill ? '0 : w_fill_next;
    end
  end

  assign o_history_next = w_history_next;
  assign o_fill_next    = w_fill_next;

endmodule

// File: rtl/seq_detector_param.sv
// Moore serial-pattern detector with run-time pattern, length and overlap mode.
// Define SEQ_DET_MATCH_CNT_EN to build the saturating match counter behind o_match_cnt.
module seq_detector_param
  import seq_det_pkg::*;
#(
  parameter int unsigned MAX_LEN = 8,
  parameter int unsigned CNT_W   = 16
) (
  input  logic                          i_clk,
  input  logic                          i_rstn,
  input  logic                          i_en,
  input  logic                          i_valid,
  input  logic                          i_seq,
  input  logic [MAX_LEN-1:0]            i_cfg_pattern,
  input  logic [$clog2(MAX_LEN+1)-1:0]  i_cfg_len,
  input  logic                          i_cfg_overlap,
  output logic                          o_out,
  output logic                          o_busy,
  output logic [CNT_W-1:0]              o_match_cnt
);

  localparam int unsigned LEN_W = $clog2(MAX_LEN + 1);

  state_e             r_state, w_state_next;
  logic [MAX_LEN-1:0] r_pat;
  logic [LEN_W-1:0]   r_len;
  logic               r_overlap;

  logic               w_latch, w_shift, w_match;
  logic [MAX_LEN-1:0] w_hist_next, w_mask;
  logic [LEN_W-1:0]   w_fill_next;

  assign w_latch = (r_state == ST_IDLE) && i_en;
  assign w_shift = (r_state != ST_IDLE) && i_en && i_valid;

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_pat     <= '0;
      r_len     <= LEN_W'(1);
      r_overlap <= 1'b0;
    end else if (w_latch) begin
      r_pat     <= i_cfg_pattern;
      r_len     <= LEN_W'(clamp_len(32'(i_cfg_len), MAX_LEN));
      r_overlap <= i_cfg_overlap;
    end
  end

  seq_det_shreg #(
    .MAX_LEN (MAX_LEN),
    .LEN_W   (LEN_W)
  ) u_shreg (
    .i_clk          (i_clk),
    .i_rstn         (i_rstn),
    .i_shift        (w_shift),
    .i_clear        (w_latch),
    .i_clear_fill   (w_match && !r_overlap),
    .i_seq          (i_seq),
    .i_len          (r_len),
    .o_history_next (w_hist_next),
    .o_fill_next    (w_fill_next)
  );

  always_comb begin
    w_mask = '0;
    for (int unsigned i = 0; i < MAX_LEN; i++) begin
      w_mask[i] = mask_bit(i, 32'(r_len));
    end
  end

  assign w_match = w_shift && (w_fill_next == r_len) &&
                   (((w_hist_next ^ r_pat) & w_mask) == '0);

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) r_state <= ST_IDLE;
    else         r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: if (i_en) w_state_next = ST_RUN;
      ST_RUN,
      ST_HIT: begin
        if (!i_en)         w_state_next = ST_IDLE;
        else if (w_match)  w_state_next = ST_HIT;
        else               w_state_next = ST_RUN;
      end
      default:             w_state_next = ST_IDLE;
    endcase
  end

  assign o_out  = (r_state == ST_HIT);
  assign o_busy = (r_state != ST_IDLE);

`ifdef SEQ_DET_MATCH_CNT_EN
  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn)                      r_cnt <= '0;
    else if (w_latch)                 r_cnt <= '0;
    else if (w_match && r_cnt != '1)  r_cnt <= r_cnt + CNT_W'(1);
  end

  assign o_match_cnt = r_cnt;
`else
  assign o_match_cnt = '0;
`endif

endmodule

// File: tb/tb_seq_detector_param.sv
// Self-checking bench for seq_detector_param: directed scenarios plus random stimulus
// against a queue-based reference model of the last received bits.
module tb_seq_detector_param;

  localparam int MAX_LEN = 8;
  localparam int CNT_W   = 2;
  localparam int LEN_W   = $clog2(MAX_LEN + 1);
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic               i_clk = 1'b0;
  logic               i_rstn, i_en, i_valid, i_seq, i_cfg_overlap;
  logic [MAX_LEN-1:0] i_cfg_pattern;
  logic [LEN_W-1:0]   i_cfg_len;
  logic               o_out, o_busy;
  logic [CNT_W-1:0]   o_match_cnt;

  seq_detector_param #(
    .MAX_LEN (MAX_LEN),
    .CNT_W   (CNT_W)
  ) dut (
    .i_clk         (i_clk),
    .i_rstn        (i_rstn),
    .i_en          (i_en),
    .i_valid       (i_valid),
    .i_seq         (i_seq),
    .i_cfg_pattern (i_cfg_pattern),
    .i_cfg_len     (i_cfg_len),
    .i_cfg_overlap (i_cfg_overlap),
    .o_out         (o_out),
    .o_busy        (o_busy),
    .o_match_cnt   (o_match_cnt)
  );

  always #5 i_clk = ~i_clk;

  int n_cmp = 0;
  int n_err = 0;
  int n_pulse = 0;

  // Reference model: bits received since the run started (or since the last
  // non-overlapping match); a match is "the newest len bits equal the pattern".
  bit             mq[$];
  bit             m_run = 0, m_out = 0, m_busy = 0, m_ov = 0;
  int             m_len = 1, m_cnt = 0;
  logic [MAX_LEN-1:0] m_pat = '0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_run = 0; m_out = 0; m_busy = 0; m_cnt = 0; mq.delete();
  endtask

  task automatic model_edge(input logic en, input logic vld, input logic sq);
    bit hit;
    if (!m_run) begin
      m_out = 0;
      if (en) begin
        m_run = 1;
        m_len = int'(i_cfg_len);
        if (m_len == 0) m_len = 1;
        if (m_len > MAX_LEN) m_len = MAX_LEN;
        m_pat = i_cfg_pattern;
        m_ov  = i_cfg_overlap;
        m_cnt = 0;
        mq.delete();
      end
    end else if (!en) begin
      m_run = 0; m_out = 0;
    end else if (vld) begin
      mq.push_back(sq);
      if (mq.size() > MAX_LEN) void'(mq.pop_front());
      hit = 0;
      if (mq.size() >= m_len) begin
        hit = 1;
        for (int k = 0; k < m_len; k++)
          if (mq[mq.size() - m_len + k] != m_pat[m_len - 1 - k]) hit = 0;
      end
      m_out = hit;
      if (hit) begin
        if (m_cnt < CNT_MAX) m_cnt++;
        if (!m_ov) mq.delete();
      end
    end else begin
      m_out = 0;
    end
    m_busy = m_run;
  endtask

  task automatic step(input logic en, input logic vld, input logic sq);
    int exp_cnt;
    @(negedge i_clk);
    i_en = en; i_valid = vld; i_seq = sq;
    model_edge(en, vld, sq);
    @(posedge i_clk);
    #1;
`ifdef SEQ_DET_MATCH_CNT_EN
    exp_cnt = m_cnt;
`else
    exp_cnt = 0;
`endif
    check_eq("out",  32'(o_out),       32'(m_out));
    check_eq("busy", 32'(o_busy),      32'(m_busy));
    check_eq("cnt",  32'(o_match_cnt), 32'(exp_cnt));
    if (o_out) n_pulse++;
  endtask

  task automatic start_run(input logic [MAX_LEN-1:0] pat, input int len, input logic ov);
    i_cfg_pattern = pat;
    i_cfg_len     = LEN_W'(len);
    i_cfg_overlap = ov;
    step(0, 0, 0);
    step(1, 0, 0);
    n_pulse = 0;
  endtask

  task automatic send_bits(input logic [15:0] bits, input int n);
    for (int i = n - 1; i >= 0; i--) step(1, 1, bits[i]);
  endtask

  initial begin
    i_rstn = 0; i_en = 0; i_valid = 0; i_seq = 0;
    i_cfg_pattern = '0; i_cfg_len = '0; i_cfg_overlap = 0;
    repeat (2) @(posedge i_clk);
    #1;
    check_eq("rst_out",  32'(o_out), 0);
    check_eq("rst_busy", 32'(o_busy), 0);
    check_eq("rst_cnt",  32'(o_match_cnt), 0);
    @(negedge i_clk);
    i_rstn = 1;
    model_reset();

    start_run(8'b1011, 4, 1);
    send_bits(16'b1011011, 7);
    check_eq("t1_pulses", n_pulse, 2);

    start_run(8'b1011, 4, 0);
    send_bits(16'b1011011, 7);
    check_eq("t2_pulses", n_pulse, 1);

    start_run(8'b1111, 3, 1);
    start_run(8'b1111, 4, 1);
    send_bits(16'b111111, 6);
    check_eq("t3_pulses", n_pulse, 3);
    check_eq("t3_hit_now", 32'(o_out), 1);

    // Asynchronous reset while in HIT: outputs must drop without a clock edge.
    @(posedge i_clk);
    #3;
    i_rstn = 0;
    #1;
    check_eq("arst_out",  32'(o_out), 0);
    check_eq("arst_busy", 32'(o_busy), 0);
    check_eq("arst_cnt",  32'(o_match_cnt), 0);
    model_reset();
    @(negedge i_clk);
    i_rstn = 1;

    start_run(8'b101, 3, 1);
    step(1, 1, 1); step(1, 0, 0); step(1, 0, 1);
    step(1, 1, 0); step(1, 0, 1); step(1, 0, 0);
    step(1, 1, 1); step(1, 0, 0); step(1, 0, 1);
    check_eq("t4_pulses", n_pulse, 1);

    start_run(8'b1011, 4, 1);
    send_bits(16'b101, 3);
    step(0, 1, 1);
    step(1, 0, 0);
    step(1, 1, 1);
    check_eq("t5_nopulse", n_pulse, 0);
    send_bits(16'b1011, 4);
    check_eq("t5_pulse", n_pulse, 1);

    start_run(8'h01, 0, 1);
    send_bits(16'b1011011, 7);
    check_eq("len0_pulses", n_pulse, 5);

    start_run(8'hA5, 12, 1);
    send_bits(16'b10100101, 8);
    check_eq("lenclamp_pulses", n_pulse, 1);

    for (int i = 0; i < 600; i++) begin
      if (i % 40 == 0) begin
        i_cfg_pattern = MAX_LEN'($urandom);
        i_cfg_len     = ($urandom_range(0, 9) == 0) ? LEN_W'($urandom_range(9, 15))
                                                    : LEN_W'($urandom_range(0, 4));
        i_cfg_overlap = 1'($urandom);
      end
      step(($urandom_range(0, 24) != 0), ($urandom_range(0, 9) < 7), 1'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
